// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory data-port arbiter.
// The request struct is sized for a 32-bit word and a 32-bit byte address.
package mem_arb_pkg;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_DATA_WIDTH = 32;

    localparam logic [3:0] WIDTH_BYTE = 4'd1;
    localparam logic [3:0] WIDTH_HALF = 4'd2;
    localparam logic [3:0] WIDTH_WORD = 4'd4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [3:0]                width;
        logic [MEM_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker; a tie goes to the port that did not win last.
// Kept generic so the instruction port can reuse it.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset value 1 makes port 0 win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/data_port_arbiter.sv
// Round-robin arbiter sharing the memory data port between the LSU (port 0)
// and the debug/loader master (port 1). Optional grant counters: DATA_PORT_ARB_PERF_CNT_EN.
module data_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic                  r0_we,
    input  logic [3:0]            r0_width,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_resp_valid,
    output logic [DATA_WIDTH-1:0] r0_rdata,

    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic                  r1_we,
    input  logic [3:0]            r1_width,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_resp_valid,
    output logic [DATA_WIDTH-1:0] r1_rdata,

`ifdef DATA_PORT_ARB_PERF_CNT_EN
    output logic [31:0]           grant_cnt0,
    output logic [31:0]           grant_cnt1,
`endif

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_width,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t            state;
    arb_state_t            next_state;
    mem_req_t              issue_q;
    mem_req_t              req0;
    mem_req_t              req1;
    logic                  issue_port;
    logic [1:0]            wait_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            valid;
    logic [1:0]            grant;
    logic                  accept_en;

    assign valid     = {r1_valid, r0_valid};
    assign accept_en = (state == IDLE) && !reset;
    assign req0      = '{addr: r0_addr, we: r0_we, width: r0_width, wdata: r0_wdata};
    assign req1      = '{addr: r1_addr, we: r1_we, width: r1_width, wdata: r1_wdata};

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .advance (accept_en),
        .grant   (grant)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (valid != 2'b00) next_state = ISSUE;
            ISSUE:   next_state = (issue_q.we || (RD_LATENCY == 0)) ? RESP : WAIT;
            WAIT:    if (wait_cnt == 2'd0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Reset gates every strobe combinationally so a write issued in the
    // reset cycle never reaches memory and no response escapes.
    always_comb begin
        r0_ready      = accept_en && grant[0];
        r1_ready      = accept_en && grant[1];
        mem_addr      = issue_q.addr;
        mem_width     = issue_q.width;
        mem_wdata     = issue_q.wdata;
        mem_we        = (state == ISSUE) && issue_q.we && !reset;
        r0_resp_valid = (state == RESP) && !issue_port && !reset;
        r1_resp_valid = (state == RESP) && issue_port && !reset;
        r0_rdata      = r0_resp_valid ? rdata_q : '0;
        r1_rdata      = r1_resp_valid ? rdata_q : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            issue_q    <= '0;
            issue_port <= 1'b0;
            wait_cnt   <= 2'd0;
            rdata_q    <= '0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && (valid != 2'b00)) begin
                issue_q    <= grant[1] ? req1 : req0;
                issue_port <= grant[1];
            end
            if (state == ISSUE) begin
                wait_cnt <= 2'(RD_LATENCY - 1);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            // Read data is valid at the memory in the last cycle before RESP.
            if (next_state == RESP) begin
                rdata_q <= issue_q.we ? '0 : mem_rdata;
            end
        end
    end

`ifdef DATA_PORT_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= 32'd0;
            grant_cnt1 <= 32'd0;
        end else begin
            if (r0_ready && (grant_cnt0 != 32'hFFFF_FFFF)) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (r1_ready && (grant_cnt1 != 32'hFFFF_FFFF)) grant_cnt1 <= grant_cnt1 + 32'd1;
        end
    end
`endif

endmodule

// File: doc/data_port_arbiter.md
Name: data_port_arbiter

Overview:
- Shares the single data port of the unified memory between two requesters: port 0 is the core load/store unit, port 1 is the debug/program-loader master.
- Each request uses a valid/ready handshake. The arbiter drives the memory data port for one transaction at a time and returns read data with a one-cycle response strobe.
- Grant policy is round-robin, so neither requester starves. The block sits between the requesters and the data_* port of the memory wrapper.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; equals memory word width.
- ADDR_WIDTH, 32, byte address width.
- RD_LATENCY, 1, cycles from address presented to read data valid at the memory; legal range 0..3.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- rN_valid  in  1  requester N (N=0,1) has a transaction pending.
- rN_ready  out  1  arbiter accepts the rN transaction this cycle.
- rN_addr  in  ADDR_WIDTH  byte address; misaligned addresses are allowed.
- rN_we  in  1  1 = write, 0 = read.
- rN_width  in  4  write width in bytes (1, 2 or 4).
- rN_wdata  in  DATA_WIDTH  write data.
- rN_resp_valid  out  1  one-cycle completion strobe for requester N.
- rN_rdata  out  DATA_WIDTH  read data; valid only while rN_resp_valid is high.
- mem_addr  out  ADDR_WIDTH  to memory data_addr.
- mem_we  out  1  to memory data_write_enable.
- mem_width  out  4  to memory data_write_width.
- mem_wdata  out  DATA_WIDTH  to memory data_write_data.
- mem_rdata  in  DATA_WIDTH  from memory data_read_data.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: all outputs are 0; state is IDLE; round-robin pointer last_grant = 1, so port 0 wins the first tie.
- State IDLE:
  - If any rN_valid is high, pick the winner: if both are valid, take the port != last_grant; otherwise take the single valid port.
  - In the same cycle: assert the winner's rN_ready (combinational), latch its addr/we/width/wdata into the issue register, update last_grant, and go to ISSUE.
  - The losing port's ready stays 0; its valid must stay asserted and its fields stable until accepted.
- State ISSUE:
  - Drive mem_* from the issue register.
  - mem_we is high for exactly this one cycle on a write.
  - Next state: RESP if RD_LATENCY = 0 or the transaction is a write; otherwise WAIT, with the counter loaded to RD_LATENCY-1.
- State WAIT:
  - Hold mem_addr; mem_we = 0.
  - Decrement the counter; at 0, go to RESP.
  - Total read latency from acceptance to resp_valid is RD_LATENCY+2 cycles (RD_LATENCY = 1 gives 3).
- State RESP:
  - Pulse rN_resp_valid for the granted port for one cycle.
  - Register rN_rdata from mem_rdata (writes return 0).
  - Return to IDLE. A new grant is possible in the cycle after RESP; there is no back-to-back overlap.
- Write latency: resp_valid is 2 cycles after acceptance.
- Fixed-width behaviour: no arithmetic on addresses; fields pass through unmodified. Address decoding and masking are done by the memory wrapper.
- Boundary conditions:
  - Both ports valid on every cycle: grants strictly alternate 0,1,0,1.
  - Only one port valid: it is granted repeatedly regardless of last_grant.
  - rN_valid dropping before acceptance is a protocol violation; behaviour is undefined.
  - Reset asserted mid-transaction: return to IDLE next cycle. mem_we = 0 and no resp_valid is issued; an in-flight write issued in the reset cycle is suppressed.
  - rN_ready and rN_resp_valid are never high for both ports in the same cycle.

Optional Feature:
- Macro: DATA_PORT_ARB_PERF_CNT_EN.
- When defined: two 32-bit saturating counters, grant_cnt0 and grant_cnt1, exposed as output ports. Each increments on acceptance for its port, saturates at 0xFFFFFFFF, and clears on reset.
- When undefined: the counters and ports are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - request struct {addr, we, width, wdata};
  - constant WIDTH_BYTE/HALF/WORD = 1/2/4.
- Sub-module rr_arbiter2: a 2-input round-robin picker holding last_grant, with inputs valid[1:0] and advance, and output onehot grant. It is natural to isolate so it can be reused for the instruction port later.

Test Plan:
- Reset, then r0 reads 0x4000 (memory preloaded 0xDEADBEEF) -> r0_ready at cycle 0, r0_resp_valid at cycle 3, r0_rdata = 0xDEADBEEF.
- Both ports valid continuously with 4 writes each -> accept order 0,1,0,1,...; mem_we pulses once per grant; each resp arrives 2 cycles after its accept.
- r1 alone writes 0x12345678 width 4 to 0x4010, then r0 reads 0x4010 -> r0_rdata = 0x12345678.
- Reset asserted during WAIT of an r0 read -> no r0_resp_valid; all outputs 0 next cycle; a subsequent r1 request is granted first only if r0 is idle.
- RD_LATENCY = 0 and 3 builds -> read resp at 2 and 5 cycles respectively; write resp stays at 2.
- With DATA_PORT_ARB_PERF_CNT_EN: 5 r0 and 3 r1 grants -> grant_cnt0 = 5, grant_cnt1 = 3; both counters return to 0 after reset.
